// File: rtl/top_link_sequencer.sv
// Host-side link sequencer for `top`: drives the serial link, services instruction and
// data memory on top's behalf and steps its CPU clock one cycle at a time.
module top_link_sequencer #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic             clk_board,
  input  logic             sys_reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] run_cycles,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycles_done,
  output logic [31:0]      last_pc,
  output logic             clk_data,
  output logic             data_sync_en,
  output logic             clk_sys,
  output logic             dataoutbit,
  input  logic             datainbit,
  input  logic             memloadf,
  input  logic             memstoref,
  output logic [29:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  output logic             dmem_re,
  output logic             dmem_we,
  input  logic             dmem_ready
);
  localparam int unsigned WaitW = $clog2(DMEM_TIMEOUT + 2);

  typedef enum logic [3:0] {
    StIdle, StSyncPc, StShiftPc, StImemReq, StImemCap, StShiftInst, StSyncInst,
    StSyncMem, StShiftAddr, StDmemRd, StShiftData, StDmemWr, StSyncData, StClkSys
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [31:0]      pc_q, inst_q, addr_q, wdata_q, rdata_q, rx_q, tx_word;
  logic             load_q, store_q, stop_q, err_q, done_q, done_d, err_set, cyc_inc;
  logic [CNT_W-1:0] cycles_q;
  logic             clk_data_q, clk_data_d, sync_q, sync_d, clk_sys_q, clk_sys_d;
  logic             seg_last, run_end;

  function automatic logic is_sync(input state_e s);
    return s inside {StSyncPc, StSyncInst, StSyncMem, StSyncData};
  endfunction

  function automatic logic is_shift(input state_e s);
    return s inside {StShiftPc, StShiftInst, StShiftAddr, StShiftData};
  endfunction

  // Last clk_board cycle of the current fixed-length segment.
  always_comb begin
    if (is_sync(state_q))        seg_last = (cnt_q == 6'd2);
    else if (is_shift(state_q))  seg_last = (cnt_q == 6'd63);
    else if (state_q == StClkSys) seg_last = (cnt_q == 6'd1);
    else                         seg_last = 1'b1;
  end

  assign run_end = ((run_cycles != '0) && ((cycles_q + CNT_W'(1)) == run_cycles)) ||
                   stop_q || stop;

  always_comb begin
    state_d = state_q;
    cnt_d   = seg_last ? 6'd0 : cnt_q + 6'd1;
    wait_d  = '0;
    done_d  = 1'b0;
    err_set = 1'b0;
    cyc_inc = 1'b0;
    unique case (state_q)
      StIdle:      if (start) state_d = StSyncPc;
      StSyncPc:    if (seg_last) state_d = StShiftPc;
      StShiftPc:   if (seg_last) state_d = StImemReq;
      StImemReq:   state_d = StImemCap;
      StImemCap:   state_d = StShiftInst;
      StShiftInst: if (seg_last) state_d = StSyncInst;
      StSyncInst:  if (seg_last) state_d = StSyncMem;
      StSyncMem:   if (seg_last) state_d = StShiftAddr;
      StShiftAddr: if (seg_last) state_d = StDmemRd;
      StDmemRd: begin
        if (!load_q || dmem_ready) begin
          state_d = StShiftData;
        end else if (wait_q == WaitW'(DMEM_TIMEOUT)) begin
          state_d = StIdle;
          err_set = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StShiftData: if (seg_last) state_d = StDmemWr;
      StDmemWr: begin
        if (!store_q || dmem_ready) begin
          state_d = StSyncData;
        end else if (wait_q == WaitW'(DMEM_TIMEOUT)) begin
          state_d = StIdle;
          err_set = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StSyncData:  if (seg_last) state_d = StClkSys;
      StClkSys: begin
        if (seg_last) begin
          cyc_inc = 1'b1;
          if (run_end) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StSyncPc;
          end
        end
      end
      default:     state_d = StIdle;
    endcase
  end

  // Link strobes are decoded from the next state so the registered copies line up with it.
  always_comb begin
    sync_d     = is_sync(state_d);
    clk_data_d = (is_sync(state_d) && (cnt_d == 6'd0)) || (is_shift(state_d) && cnt_d[0]);
    clk_sys_d  = (state_d == StClkSys) && (cnt_d == 6'd0);
  end

  always_comb begin
    tx_word = '0;
    if (state_q == StShiftInst)      tx_word = inst_q;
    else if (state_q == StShiftData) tx_word = rdata_q;
  end

  always_ff @(posedge clk_board or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wait_q     <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rx_q       <= '0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      stop_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      cycles_q   <= '0;
      clk_data_q <= 1'b0;
      sync_q     <= 1'b0;
      clk_sys_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      clk_data_q <= clk_data_d;
      sync_q     <= sync_d;
      clk_sys_q  <= clk_sys_d;
      done_q     <= done_d;
      if (is_shift(state_q) && !cnt_q[0]) rx_q[cnt_q[5:1]] <= datainbit;
      if (seg_last && (state_q == StShiftPc)) pc_q <= rx_q;
      if (seg_last && (state_q == StShiftAddr)) begin
        addr_q  <= rx_q;
        load_q  <= memloadf;
        store_q <= memstoref;
      end
      if (seg_last && (state_q == StShiftData)) wdata_q <= rx_q;
      if (state_q == StImemCap) inst_q <= imem_rdata;
      if (state_q == StDmemRd) begin
        if (!load_q)         rdata_q <= '0;
        else if (dmem_ready) rdata_q <= dmem_rdata;
      end
      if ((state_q == StIdle) && start) begin
        cycles_q <= '0;
        err_q    <= 1'b0;
        stop_q   <= 1'b0;
      end else begin
        if (cyc_inc) cycles_q <= cycles_q + CNT_W'(1);
        if (err_set) err_q <= 1'b1;
        if (state_d == StIdle) stop_q <= 1'b0;
        else if (stop)         stop_q <= 1'b1;
      end
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err          = err_q;
  assign cycles_done  = cycles_q;
  assign last_pc      = pc_q;
  assign clk_data     = clk_data_q;
  assign data_sync_en = sync_q;
  assign clk_sys      = clk_sys_q;
  assign dataoutbit   = is_shift(state_q) && tx_word[cnt_q[5:1]];
  assign imem_addr    = pc_q[31:2];
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_re      = (state_q == StDmemRd) && load_q;
  assign dmem_we      = (state_q == StDmemWr) && store_q;

endmodule

// File: tb/tb_top_link_sequencer.sv
// Bench for top_link_sequencer: plays `top` and both memories, and checks every clk_board
// cycle against a timeline model built from segment lengths of one CPU cycle.
module tb_top_link_sequencer;
  localparam int TMO = 255;

  logic        clk_board   = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic        start       = 1'b0;
  logic        stop        = 1'b0;
  logic [15:0] run_cycles  = '0;
  logic        busy, done, err;
  logic [15:0] cycles_done;
  logic [31:0] last_pc;
  logic        clk_data, data_sync_en, clk_sys, dataoutbit;
  logic        datainbit  = 1'b0;
  logic        memloadf   = 1'b0;
  logic        memstoref  = 1'b0;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_re, dmem_we;
  logic        dmem_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  top_link_sequencer dut (
    .clk_board(clk_board), .sys_reset_n(sys_reset_n), .start(start), .stop(stop),
    .run_cycles(run_cycles), .busy(busy), .done(done), .err(err),
    .cycles_done(cycles_done), .last_pc(last_pc), .clk_data(clk_data),
    .data_sync_en(data_sync_en), .clk_sys(clk_sys), .dataoutbit(dataoutbit),
    .datainbit(datainbit), .memloadf(memloadf), .memstoref(memstoref),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_re(dmem_re),
    .dmem_we(dmem_we), .dmem_ready(dmem_ready)
  );

  always #5 clk_board = ~clk_board;

  function automatic logic [31:0] imem_f(input logic [29:0] a);
    if (a == 30'd0) return 32'h0000_0013;
    return ({a, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Instruction memory with a fixed one-cycle read latency.
  always @(posedge clk_board) imem_rdata <= imem_f(imem_addr);

  // Observer acting as `top`'s receiver: collects words on clk_data rising outside sync.
  logic        prev_cd = 1'b0;
  logic [31:0] cap     = '0;
  int          cap_n   = 0;
  logic [31:0] words[$];
  int          sys_pulses = 0;
  int          re_cyc     = 0;
  int          we_cyc     = 0;

  always @(negedge clk_board) begin
    if (!sys_reset_n) begin
      cap_n = 0;
    end else if (clk_data && !prev_cd && !data_sync_en) begin
      cap   = {dataoutbit, cap[31:1]};
      cap_n = cap_n + 1;
      if (cap_n == 32) begin
        words.push_back(cap);
        cap_n = 0;
      end
    end
    prev_cd = clk_data;
    if (clk_sys) sys_pulses = sys_pulses + 1;
    if (dmem_re) re_cyc = re_cyc + 1;
    if (dmem_we) we_cyc = we_cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{busy, done, err, cycles_done, last_pc, clk_data, data_sync_en, clk_sys,
             dataoutbit, imem_addr, dmem_addr, dmem_wdata, dmem_re, dmem_we};
  endfunction

  task automatic start_run(input int n, input bit with_stop);
    start      = 1'b1;
    stop       = with_stop;
    run_cycles = 16'(n);
    @(negedge clk_board);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // One CPU cycle seen from offset 0; called and returns on a falling edge.
  task automatic cpu_cycle(input logic [31:0] pc, input bit load, input bit store,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int rd_dly, input int wr_dly,
                           input int cd, input bit timeout, input int stop_at,
                           input int start_at, input int reset_at);
    int l1, l2, s_sd, s_wr, s_sy, s_cs, total, j, base;
    logic [31:0] inst, txw, rxw;
    logic e_sync, e_cd, e_cs, e_do, e_re, e_we;
    inst  = imem_f(pc[31:2]);
    l1    = timeout ? TMO + 1 : (load ? rd_dly + 1 : 1);
    l2    = store ? wr_dly + 1 : 1;
    s_sd  = 203 + l1;
    s_wr  = s_sd + 64;
    s_sy  = s_wr + l2;
    s_cs  = s_sy + 3;
    total = timeout ? s_sd : s_cs + 2;
    for (int t = 0; t < total; t++) begin
      if (t == reset_at) begin
        sys_reset_n = 1'b0;
        #1;
        check("reset_mid_cycle", 64'(any_out()), 64'd0);
        @(negedge clk_board);
        sys_reset_n = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        return;
      end
      {e_sync, e_cd, e_cs, e_do} = 4'b0;
      base = -1;
      txw  = '0;
      rxw  = '0;
      datainbit = 1'($urandom);
      if (t < 3)                      j = t;
      else if (t >= 133 && t < 139)   j = (t - 133) % 3;
      else if (t >= s_sy && t < s_cs) j = t - s_sy;
      else                            j = -1;
      if (j >= 0) begin
        e_sync = 1'b1;
        e_cd   = (j == 0);
      end
      if (t >= 3 && t < 67)              begin base = 3;    txw = '0;   rxw = pc;       end
      else if (t >= 69 && t < 133)       begin base = 69;   txw = inst; rxw = $urandom; end
      else if (t >= 139 && t < 203)      begin base = 139;  txw = '0;   rxw = addr;     end
      else if (t >= s_sd && t < s_wr)    begin base = s_sd; txw = load ? rdata : '0;
                                               rxw = wdata; end
      if (base >= 0) begin
        j    = t - base;
        e_cd = (j % 2 == 1);
        e_do = txw[j/2];
        if (j % 2 == 0) datainbit = rxw[j/2];
      end
      e_re = load && (t >= 203) && (t < s_sd);
      e_we = store && (t >= s_wr) && (t < s_sy);
      e_cs = (t == s_cs);
      dmem_ready = 1'($urandom);
      dmem_rdata = $urandom;
      if (e_re) begin
        dmem_ready = !timeout && (t == s_sd - 1);
        if (dmem_ready) dmem_rdata = rdata;
      end
      if (e_we) dmem_ready = (t == s_sy - 1);
      memloadf  = (t >= 139) ? load  : 1'($urandom);
      memstoref = (t >= 139) ? store : 1'($urandom);
      stop  = (t == stop_at);
      start = (t == start_at);
      check($sformatf("c%0d_t%0d_outputs", cd, t),
            64'({busy, done, err, data_sync_en, clk_data, clk_sys, dataoutbit, dmem_re, dmem_we}),
            64'({1'b1, 1'b0, 1'b0, e_sync, e_cd, e_cs, e_do, e_re, e_we}));
      if (t == 0) check("cycles_done_at_start", 64'(cycles_done), 64'(cd));
      if (t == 67) begin
        check("last_pc", 64'(last_pc), 64'(pc));
        check("imem_addr", 64'(imem_addr), 64'(pc[31:2]));
      end
      if (t == 203)  check("dmem_addr", 64'(dmem_addr), 64'(addr));
      if (t == s_wr) check("dmem_wdata", 64'(dmem_wdata), 64'(wdata));
      @(negedge clk_board);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic end_check(input string name, input int cd, input bit exp_done, input bit exp_err);
    check({name, "_idle"},
          64'({busy, done, err, data_sync_en, clk_data, clk_sys, dataoutbit, dmem_re, dmem_we}),
          64'({1'b0, exp_done, exp_err, 6'b0}));
    check({name, "_cycles_done"}, 64'(cycles_done), 64'(cd));
    @(negedge clk_board);
    check({name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no summary, expected run to end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t0;
    int  s0, r0, w0, q0, n;
    repeat (3) @(negedge clk_board);
    check("reset_hold", 64'(any_out()), 64'd0);
    sys_reset_n = 1'b1;
    @(negedge clk_board);
    check("after_reset", 64'(any_out()), 64'd0);

    // Single plain cycle, PC 0 -> instruction 0x13.
    start_run(1, 1'b0);
    t0 = $time; s0 = sys_pulses; q0 = words.size();
    cpu_cycle(32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, -1, -1, -1);
    check("t1_length", 64'(($time - t0) / 10), 64'd274);
    check("t1_clk_sys_pulses", 64'(sys_pulses - s0), 64'd1);
    check("t1_word_count", 64'(words.size() - q0), 64'd4);
    check("t1_inst_word", 64'(words[q0+1]), 64'h13);
    end_check("t1", 1, 1, 0);

    // Load with ready delayed five cycles.
    start_run(1, 1'b0);
    t0 = $time; r0 = re_cyc; q0 = words.size();
    cpu_cycle(32'h4, 1, 0, 32'h100, 32'h1234_5678, 32'hEAD, 5, 0, 0, 0, -1, -1, -1);
    check("t2_length", 64'(($time - t0) / 10), 64'd279);
    check("t2_re_cycles", 64'(re_cyc - r0), 64'd6);
    check("t2_data_word", 64'(words[q0+3]), 64'hEAD);
    end_check("t2", 1, 1, 0);

    // Store with ready delayed two cycles.
    start_run(1, 1'b0);
    w0 = we_cyc; q0 = words.size();
    cpu_cycle(32'h8, 0, 1, 32'h200, 32'hDEAD_BEEF, 32'h0, 0, 2, 0, 0, -1, -1, -1);
    check("t3_we_cycles", 64'(we_cyc - w0), 64'd3);
    check("t3_data_word", 64'(words[q0+3]), 64'd0);
    check("t3_wdata", 64'(dmem_wdata), 64'hDEAD_BEEF);
    check("t3_addr", 64'(dmem_addr), 64'h200);
    end_check("t3", 1, 1, 0);

    // Free run stopped inside the fourth cycle; a start pulse while busy is ignored.
    start_run(0, 1'b0);
    s0 = sys_pulses;
    for (int c = 0; c < 4; c++)
      cpu_cycle(32'(c * 4), c[0], c[1], 32'(c * 16), $urandom, $urandom, 1, 1, c, 0,
                (c == 3) ? 100 : -1, (c == 1) ? 50 : -1, -1);
    check("t4_clk_sys_pulses", 64'(sys_pulses - s0), 64'd4);
    end_check("t4", 4, 1, 0);

    // Load timeout, then a fresh start clears err.
    start_run(1, 1'b0);
    s0 = sys_pulses; r0 = re_cyc;
    cpu_cycle(32'hC, 1, 0, 32'h300, 32'h0, 32'h0, 0, 0, 0, 1, -1, -1, -1);
    check("t5_re_cycles", 64'(re_cyc - r0), 64'(TMO + 1));
    check("t5_no_clk_sys", 64'(sys_pulses - s0), 64'd0);
    end_check("t5", 0, 0, 1);
    start_run(1, 1'b0);
    cpu_cycle(32'h10, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, -1, -1, -1);
    end_check("t5b", 1, 1, 0);

    // Start and stop together from idle: start wins.
    start_run(2, 1'b1);
    for (int c = 0; c < 2; c++)
      cpu_cycle(32'h20, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, c, 0, -1, -1, -1);
    end_check("start_stop", 2, 1, 0);

    // Reset during address shift, then a clean rerun of the first case.
    start_run(1, 1'b0);
    cpu_cycle(32'h0, 1, 1, 32'h40, 32'h1, 32'h2, 0, 0, 0, 0, -1, -1, 150);
    check("t6_idle_after_reset", 64'(any_out()), 64'd0);
    start_run(1, 1'b0);
    t0 = $time; q0 = words.size();
    cpu_cycle(32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, -1, -1, -1);
    check("t6_length", 64'(($time - t0) / 10), 64'd274);
    check("t6_inst_word", 64'(words[q0+1]), 64'h13);
    end_check("t6", 1, 1, 0);

    // Randomised runs.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 3);
      start_run(n, 1'b0);
      for (int c = 0; c < n; c++)
        cpu_cycle($urandom, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), c, 0, -1, -1, -1);
      end_check("rand", n, 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
